// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: op encoding, FSM states, defaults.
package mem_stage_lsu_pkg;

    localparam int unsigned WaitLimitDefault = 16;

    typedef enum logic [3:0] {
        OpNone = 4'd0,
        OpLw   = 4'd1,
        OpLh   = 4'd2,
        OpLhu  = 4'd3,
        OpLb   = 4'd4,
        OpLbu  = 4'd5,
        OpSw   = 4'd6,
        OpSh   = 4'd7,
        OpSb   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } lsu_state_e;

    function automatic logic is_load(input mem_op_e op);
        return op inside {OpLw, OpLh, OpLhu, OpLb, OpLbu};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {OpSw, OpSh, OpSb};
    endfunction

    function automatic logic misaligned(input mem_op_e op, input logic [1:0] off);
        if (op inside {OpLw, OpSw}) return off != 2'b00;
        if (op inside {OpLh, OpLhu, OpSh}) return off[0];
        return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replication, load extract and extend.
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

        // Loads always read the full word; lane selection happens on return.
        be      = 4'b1111;
        st_word = '0;
        ld_data = '0;
        case (op)
            OpSw: st_word = st_data;
            OpSh: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                st_word = {2{st_data[15:0]}};
            end
            OpSb: begin
                be      = 4'b0001 << off;
                st_word = {4{st_data[7:0]}};
            end
            OpLw:    ld_data = rd_word;
            OpLh:    ld_data = {{16{rd_half[15]}}, rd_half};
            OpLhu:   ld_data = {16'h0000, rd_half};
            OpLb:    ld_data = {{24{rd_byte[7]}}, rd_byte};
            OpLbu:   ld_data = {24'h000000, rd_byte};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: accepts M-stage ops, runs one req/ack bus access with timeout, returns load data.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = WaitLimitDefault,
    parameter int unsigned OP_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] mem_op,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic            stall,
    output logic            done,
    output logic [31:0]     load_data,
    output logic            exc_adel,
    output logic            exc_ades,
    output logic            bus_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [31:0]     bus_addr,
    output logic [3:0]      bus_be,
    output logic [31:0]     bus_wdata,
    input  logic            bus_ack,
    input  logic [31:0]     bus_rdata
);

    lsu_state_e  state;
    mem_op_e     op_q;
    mem_op_e     op_dec;
    mem_op_e     lane_op;
    logic [1:0]  off_q;
    logic [1:0]  lane_off;
    logic [7:0]  wait_cnt;
    logic        bad_align;
    logic        accept;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_ld;

    always_comb begin
        op_dec    = (mem_op > OP_W'(8)) ? OpNone : mem_op_e'(mem_op[3:0]);
        bad_align = misaligned(op_dec, addr[1:0]);
        accept    = (state == StIdle) && (op_dec != OpNone) && !bad_align;
        exc_adel  = (state == StIdle) && is_load(op_dec) && bad_align;
        exc_ades  = (state == StIdle) && is_store(op_dec) && bad_align;
        stall     = accept || (state == StBusy);
        // Idle steers the incoming store; busy extracts using the latched op.
        lane_op   = (state == StIdle) ? op_dec : op_q;
        lane_off  = (state == StIdle) ? addr[1:0] : off_q;
    end

    lsu_lane_align u_lane_align (
        .op      (lane_op),
        .off     (lane_off),
        .st_data (wdata),
        .rd_word (bus_rdata),
        .be      (lane_be),
        .st_word (lane_wdata),
        .ld_data (lane_ld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            op_q      <= OpNone;
            off_q     <= 2'b00;
            wait_cnt  <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            load_data <= '0;
            done      <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                    if (accept) begin
                        state     <= StBusy;
                        op_q      <= op_dec;
                        off_q     <= addr[1:0];
                        wait_cnt  <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= is_store(op_dec);
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= lane_be;
                        bus_wdata <= lane_wdata;
                    end
                end
                StBusy: begin
                    if (bus_ack) begin
                        state     <= StDone;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        done      <= 1'b1;
                        load_data <= lane_ld;
                    end else if (wait_cnt == 8'(WAIT_LIMIT - 1)) begin
                        // Last permitted cycle passed without ack: abandon the access.
                        state     <= StDone;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        done      <= 1'b1;
                        bus_err   <= 1'b1;
                        load_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                StDone: begin
                    state   <= StIdle;
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, hand sequences, and randomized ops vs a model.
module tb_mem_stage_lsu;

    localparam int WL = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mem_op;
    logic [31:0] addr, wdata;
    logic        stall, done, exc_adel, exc_ades, bus_err;
    logic        bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu #(
        .WAIT_LIMIT (WL),
        .OP_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_op    (mem_op),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .load_data (load_data),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: kind 0=access, 1=load misaligned, 2=store misaligned, 3=no op.
    function automatic int model_kind(input int op, input int off);
        if (op == 0 || op > 8) return 3;
        if ((op == 1 || op == 6) && off != 0) return (op == 1) ? 1 : 2;
        if ((op == 2 || op == 3 || op == 7) && (off % 2) != 0) return (op == 7) ? 2 : 1;
        return 0;
    endfunction

    function automatic logic [3:0] model_be(input int op, input int off);
        if (op == 7) return (off >= 2) ? 4'd12 : 4'd3;
        if (op == 8) return 4'(1 << off);
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wd(input int op, input logic [31:0] wd);
        if (op == 6) return wd;
        if (op == 7) return (wd & 32'hFFFF) * 32'h0001_0001;
        if (op == 8) return (wd & 32'hFF) * 32'h0101_0101;
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_ld(input int op, input int off, input logic [31:0] rd);
        logic [31:0] v;
        case (op)
            1: v = rd;
            2, 3: begin
                v = (rd >> (off * 8)) & 32'hFFFF;
                if (op == 2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            4, 5: begin
                v = (rd >> (off * 8)) & 32'hFF;
                if (op == 4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // ack_cyc: BUSY cycle (1-based) on which bus_ack is given; beyond WL means never.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_cyc, input int kind,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld,
                          input logic ewe, input logic eerr, input string tag);
        int busy_n;
        int stalls;
        @(negedge clk);
        mem_op = op; addr = a; wdata = wd; bus_rdata = rd; bus_ack = 1'b0;
        #1;
        chk({tag, " exc_adel"}, 32'(exc_adel), 32'(kind == 1));
        chk({tag, " exc_ades"}, 32'(exc_ades), 32'(kind == 2));
        chk({tag, " accept stall"}, 32'(stall), 32'(kind == 0));
        if (kind != 0) begin
            @(posedge clk); #1 mem_op = 4'd0;
            @(negedge clk);
            chk({tag, " no bus_req"}, 32'(bus_req), 32'd0);
            chk({tag, " no done"}, 32'(done), 32'd0);
            return;
        end
        stalls = int'(stall);
        busy_n = (ack_cyc >= 1 && ack_cyc <= WL) ? ack_cyc : WL;
        for (int k = 1; k <= busy_n; k++) begin
            @(negedge clk);
            chk({tag, " busy bus_req"}, 32'(bus_req), 32'd1);
            chk({tag, " busy done"}, 32'(done), 32'd0);
            if (k == 1 || k == busy_n) begin
                chk({tag, " bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
                chk({tag, " bus_be"}, 32'(bus_be), 32'(ebe));
                chk({tag, " bus_we"}, 32'(bus_we), 32'(ewe));
                if (ewe) chk({tag, " bus_wdata"}, bus_wdata, ewd);
            end
            stalls += int'(stall);
            if (k == ack_cyc) bus_ack = 1'b1;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = $urandom();
        stalls += int'(stall);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " bus_err"}, 32'(bus_err), 32'(eerr));
        chk({tag, " done bus_req"}, 32'(bus_req), 32'd0);
        if (!ewe || eerr) chk({tag, " load_data"}, load_data, eld);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(1 + busy_n));
        // Op is still held through DONE; it must not be taken again.
        @(posedge clk); #1 mem_op = 4'd0;
        @(negedge clk);
        chk({tag, " after done"}, 32'(done), 32'd0);
        chk({tag, " no re-accept"}, 32'(bus_req), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, wd, rd;
        int          ack, kind;
        logic [3:0]  be;
        logic [31:0] ewd, eld;
        logic        we, err;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack, input int kind, input logic [3:0] be,
                       input logic [31:0] ewd, input logic [31:0] eld, input logic we,
                       input logic err, input string tag);
        vec_t v;
        v.op = op; v.a = a; v.wd = wd; v.rd = rd; v.ack = ack; v.kind = kind; v.be = be;
        v.ewd = ewd; v.eld = eld; v.we = we; v.err = err; v.tag = tag;
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rwd, rrd;
        int          rack, rk, off;

        reset = 1'b1; mem_op = 4'd0; addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset bus_req", 32'(bus_req), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        chk("reset bus_we", 32'(bus_we), 32'd0);
        chk("reset bus_addr", bus_addr, 32'd0);
        chk("reset bus_be", 32'(bus_be), 32'd0);
        chk("reset bus_wdata", bus_wdata, 32'd0);
        chk("reset load_data", load_data, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        reset = 1'b0;

        //  op     addr          wdata         rdata        ack kind be     ewd           eld           we    err
        add(4'd1, 32'h100, 32'h0,        32'hDEADBEEF, 2,  0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, "lw");
        add(4'd8, 32'h103, 32'h000000A5, 32'h11111111, 1,  0, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b1, 1'b0, "sb");
        add(4'd4, 32'h102, 32'h0,        32'h12F05678, 1,  0, 4'hF, 32'h0,        32'hFFFFFFF0, 1'b0, 1'b0, "lb");
        add(4'd5, 32'h102, 32'h0,        32'h12F05678, 3,  0, 4'hF, 32'h0,        32'h000000F0, 1'b0, 1'b0, "lbu");
        add(4'd2, 32'h102, 32'h0,        32'h12F05678, 1,  0, 4'hF, 32'h0,        32'h000012F0, 1'b0, 1'b0, "lh");
        add(4'd2, 32'h100, 32'h0,        32'h00008001, 1,  0, 4'hF, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, "lh neg");
        add(4'd3, 32'h100, 32'h0,        32'h00008001, 1,  0, 4'hF, 32'h0,        32'h00008001, 1'b0, 1'b0, "lhu");
        add(4'd7, 32'h102, 32'h1234BEEF, 32'h0,        2,  0, 4'hC, 32'hBEEFBEEF, 32'h0,        1'b1, 1'b0, "sh hi");
        add(4'd6, 32'h200, 32'hCAFEF00D, 32'h0,        1,  0, 4'hF, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, "sw");
        add(4'd1, 32'h101, 32'h0,        32'h0,        1,  1, 4'hF, 32'h0,        32'h0,        1'b0, 1'b0, "lw misalign");
        add(4'd7, 32'h001, 32'h0,        32'h0,        1,  2, 4'hF, 32'h0,        32'h0,        1'b1, 1'b0, "sh misalign");
        add(4'd6, 32'h202, 32'h0,        32'h0,        1,  2, 4'hF, 32'h0,        32'h0,        1'b1, 1'b0, "sw misalign");
        add(4'd9, 32'h100, 32'h0,        32'h0,        1,  3, 4'hF, 32'h0,        32'h0,        1'b0, 1'b0, "op 9 none");
        add(4'd1, 32'h300, 32'h0,        32'h55AA55AA, 99, 0, 4'hF, 32'h0,        32'h0,        1'b0, 1'b1, "lw timeout");
        add(4'd1, 32'h300, 32'h0,        32'h55AA55AA, WL, 0, 4'hF, 32'h0,        32'h55AA55AA, 1'b0, 1'b0, "lw ack at limit");

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].ack, tbl[i].kind, tbl[i].be,
                   tbl[i].ewd, tbl[i].eld, tbl[i].we, tbl[i].err, tbl[i].tag);

        // bus_ack while idle must not produce a completion.
        @(negedge clk); bus_ack = 1'b1;
        @(negedge clk); bus_ack = 1'b0;
        chk("idle ack done", 32'(done), 32'd0);
        chk("idle ack bus_req", 32'(bus_req), 32'd0);

        // Reset while a request is outstanding abandons it without a done pulse.
        @(negedge clk); mem_op = 4'd1; addr = 32'h400;
        @(negedge clk);
        chk("rst busy bus_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst drop bus_req", 32'(bus_req), 32'd0);
        chk("rst drop done", 32'(done), 32'd0);
        reset = 1'b0; mem_op = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst no done", 32'(done), 32'd0);
            chk("rst no req", 32'(bus_req), 32'd0);
        end
        run_op(4'd1, 32'h400, 32'h0, 32'h0BADF00D, 1, 0, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, 1'b0,
               "lw after reset");

        for (int i = 0; i < 40; i++) begin
            rop  = 4'($urandom_range(0, 15));
            ra   = $urandom();
            rwd  = $urandom();
            rrd  = $urandom();
            rack = $urandom_range(1, 20);
            off  = int'(ra[1:0]);
            rk   = model_kind(int'(rop), off);
            run_op(rop, ra, rwd, rrd, rack, rk, model_be(int'(rop), off),
                   model_wd(int'(rop), rwd),
                   (rack > WL) ? 32'h0 : model_ld(int'(rop), off, rrd),
                   rop >= 4'd6 && rop <= 4'd8, rack > WL, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
